// File: rtl/dafx_gain_ramp_ctrl.sv
// Zipper-free gain sequencer: each frame strobe scans all gain slots once, moving every
// live mixer gain toward its software target by at most one step without overshooting.
module dafx_gain_ramp_ctrl #(
  parameter int NR_OF_CHANNELS_P = 3,
  parameter int GAIN_WIDTH_P     = 24,
  parameter int STEP_WIDTH_P     = 16
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           fs_strobe,
  input  logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]  cr_target_gain,
  input  logic [GAIN_WIDTH_P-1:0]                        cr_target_output_gain,
  input  logic [STEP_WIDTH_P-1:0]                        cr_ramp_step,
  input  logic                                           cmd_gain_snap,
  output logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]  ramp_gain,
  output logic [GAIN_WIDTH_P-1:0]                        ramp_output_gain,
  output logic                                           ramp_busy,
  output logic                                           ramp_done,
  output logic [NR_OF_CHANNELS_P:0]                      sr_ramp_active,
  output logic [15:0]                                    sr_overrun_count
);

  localparam int NS     = NR_OF_CHANNELS_P + 1;
  localparam int GW     = GAIN_WIDTH_P;
  localparam int SLOT_W = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NR_OF_CHANNELS_P);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [NS-1:0][GW-1:0]  gain_q, gain_d;
  logic [NS-1:0]          active_q, active_d;
  logic [15:0]            ovr_q, ovr_d;

  logic [NS-1:0][GW-1:0]  tgt_all;
  logic [GW-1:0]          cur, tgt, nxt, step_g;
  logic signed [GW:0]     diff;
  logic [GW:0]            mag, step_ext;

  // The output gain rides along as the last slot so one datapath serves every gain.
  assign tgt_all = {cr_target_output_gain, cr_target_gain};

  always_comb begin
    cur      = gain_q[slot_q];
    tgt      = tgt_all[slot_q];
    step_g   = GW'(cr_ramp_step);
    step_ext = {1'b0, step_g};
    diff     = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag      = diff[GW] ? $unsigned(-diff) : $unsigned(diff);
    if (cur == tgt) begin
      nxt = cur;
    end else if (cr_ramp_step == '0 || mag <= step_ext) begin
      nxt = tgt;
    end else if (!diff[GW]) begin
      nxt = cur + step_g;
    end else begin
      nxt = cur - step_g;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      gain_q   <= '0;
      active_q <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      gain_q   <= gain_d;
      active_q <= active_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cmd_gain_snap) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (fs_strobe) state_d = SCAN;
        SCAN:    if (slot_q == LAST_SLOT) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Slot counter, gain datapath and overrun counter; snap overrides everything.
  always_comb begin
    slot_d   = '0;
    gain_d   = gain_q;
    active_d = active_q;
    ovr_d    = ovr_q;
    if (cmd_gain_snap) begin
      gain_d   = tgt_all;
      active_d = '0;
    end else begin
      if (state_q == SCAN) begin
        slot_d           = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        gain_d[slot_q]   = nxt;
        active_d[slot_q] = (nxt != tgt);
      end
      if (fs_strobe && state_q != IDLE && ovr_q != 16'hFFFF) begin
        ovr_d = ovr_q + 16'd1;
      end
    end
  end

  always_comb begin
    ramp_busy        = (state_q != IDLE);
    ramp_done        = (state_q == DONE);
    ramp_gain        = gain_q[NS-2:0];
    ramp_output_gain = gain_q[NS-1];
    sr_ramp_active   = active_q;
    sr_overrun_count = ovr_q;
  end

endmodule

// File: tb/tb_dafx_gain_ramp_ctrl.sv
// Bench for dafx_gain_ramp_ctrl: directed and randomized frames scored against a
// per-scan arithmetic model; expected results queue up and are popped on ramp_done.
module tb_dafx_gain_ramp_ctrl;
  localparam int NCH = 3;
  localparam int GW  = 24;
  localparam int SW  = 16;
  localparam int NS  = NCH + 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     fs_strobe = 1'b0;
  logic                     cmd_gain_snap = 1'b0;
  logic [NCH-1:0][GW-1:0]   cr_target_gain = '0;
  logic [GW-1:0]            cr_target_output_gain = '0;
  logic [SW-1:0]            cr_ramp_step = '0;
  logic [NCH-1:0][GW-1:0]   ramp_gain;
  logic [GW-1:0]            ramp_output_gain;
  logic                     ramp_busy;
  logic                     ramp_done;
  logic [NCH:0]             sr_ramp_active;
  logic [15:0]              sr_overrun_count;

  dafx_gain_ramp_ctrl #(
    .NR_OF_CHANNELS_P(NCH), .GAIN_WIDTH_P(GW), .STEP_WIDTH_P(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fs_strobe(fs_strobe),
    .cr_target_gain(cr_target_gain), .cr_target_output_gain(cr_target_output_gain),
    .cr_ramp_step(cr_ramp_step), .cmd_gain_snap(cmd_gain_snap),
    .ramp_gain(ramp_gain), .ramp_output_gain(ramp_output_gain),
    .ramp_busy(ramp_busy), .ramp_done(ramp_done),
    .sr_ramp_active(sr_ramp_active), .sr_overrun_count(sr_overrun_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0][GW-1:0] g;
    logic [NS-1:0]         act;
  } exp_t;

  exp_t          exp_q[$];
  logic [GW-1:0] m_gain [NS];
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference rule: move by step toward target, land exactly on it when within reach.
  function automatic logic [GW-1:0] ramp_model(input longint cur, input longint tgt, input longint stp);
    longint d = tgt - cur;
    longint a = (d >= 0) ? d : -d;
    if (stp == 0 || a <= stp) return GW'(tgt);
    if (d > 0) return GW'(cur + stp);
    return GW'(cur - stp);
  endfunction

  function automatic logic [GW-1:0] tgt_of(input int k);
    return (k < NCH) ? cr_target_gain[k] : cr_target_output_gain;
  endfunction

  task automatic push_scan_with(input logic [GW-1:0] t [NS]);
    exp_t e;
    for (int k = 0; k < NS; k++) begin
      m_gain[k] = ramp_model(m_gain[k], t[k], cr_ramp_step);
      e.g[k]    = m_gain[k];
      e.act[k]  = (m_gain[k] != t[k]);
    end
    exp_q.push_back(e);
  endtask

  task automatic push_scan();
    logic [GW-1:0] t [NS];
    for (int k = 0; k < NS; k++) t[k] = tgt_of(k);
    push_scan_with(t);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic do_scan();
    fs_strobe = 1'b1;
    push_scan();
    @(posedge clk); #1;
    fs_strobe = 1'b0;
    chk("busy_after_strobe", ramp_busy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_not_early", ramp_done, 0);
    @(posedge clk);
    @(negedge clk);
    chk("done_at_e4", ramp_done, 1);
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_scan", ramp_busy, 0);
    chk("done_one_cycle", ramp_done, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic snap_model();
    for (int k = 0; k < NS; k++) m_gain[k] = tgt_of(k);
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en && ramp_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < NCH; k++) chk($sformatf("gain[%0d]", k), ramp_gain[k], e.g[k]);
        chk("output_gain", ramp_output_gain, e.g[NS-1]);
        chk("ramp_active", sr_ramp_active, e.act);
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [GW-1:0] t [NS];
    logic [15:0]   ovr0;
    logic [GW-1:0] up_exp [5];
    bit            hit;
    up_exp[0] = 24'h100; up_exp[1] = 24'h200; up_exp[2] = 24'h300;
    up_exp[3] = 24'h400; up_exp[4] = 24'h400;
    for (int k = 0; k < NS; k++) m_gain[k] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gain0", ramp_gain[0], 0);
    chk("rst_outgain", ramp_output_gain, 0);
    chk("rst_busy", ramp_busy, 0);
    chk("rst_done", ramp_done, 0);
    chk("rst_active", sr_ramp_active, 0);
    chk("rst_overrun", sr_overrun_count, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Up-ramp
    cr_ramp_step = 16'h100;
    cr_target_gain[0] = 24'h400;
    for (int i = 0; i < 5; i++) begin
      do_scan();
      chk("upramp_g0", ramp_gain[0], up_exp[i]);
      chk("upramp_act0", sr_ramp_active[0], (i < 3) ? 1 : 0);
    end

    // Clamp up: reach 0x380 via step 0, then step 0x100 toward 0x400
    cr_ramp_step = 16'h0;
    cr_target_gain[0] = 24'h380;
    do_scan();
    chk("jump_g0", ramp_gain[0], 24'h380);
    cr_ramp_step = 16'h100;
    cr_target_gain[0] = 24'h400;
    do_scan();
    chk("clamp_up", ramp_gain[0], 24'h400);
    // Clamp down
    cr_ramp_step = 16'h300;
    cr_target_gain[0] = 24'h0;
    do_scan();
    chk("down_1", ramp_gain[0], 24'h100);
    do_scan();
    chk("clamp_down", ramp_gain[0], 24'h0);

    // Step zero on the output slot
    cr_ramp_step = 16'h0;
    cr_target_output_gain = 24'h7FFFFF;
    do_scan();
    chk("out_jump", ramp_output_gain, 24'h7FFFFF);

    // Target change mid-scan: slot 0 already processed, later slots see new values
    cr_ramp_step = 16'h10;
    cr_target_gain = {24'h500, 24'h500, 24'h500};
    fs_strobe = 1'b1;
    t[0] = tgt_of(0);
    @(posedge clk); #1;
    fs_strobe = 1'b0;
    @(posedge clk); #1;
    cr_target_gain = {24'h000, 24'h000, 24'h000};
    cr_target_output_gain = 24'h000;
    for (int k = 1; k < NS; k++) t[k] = tgt_of(k);
    push_scan_with(t);
    repeat (10) @(posedge clk);
    #1;
    chk("midscan_g0", ramp_gain[0], 24'h10);

    // Randomized frames
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < NCH; k++)
        cr_target_gain[k] = ($urandom_range(0, 1) == 0) ? GW'($urandom) : GW'($urandom_range(0, 24'h3000));
      cr_target_output_gain = GW'($urandom);
      cr_ramp_step = ($urandom_range(0, 3) == 0) ? 16'h0 : SW'($urandom);
      repeat ($urandom_range(1, 3)) do_scan();
    end

    // Overrun: strobes at E0 and E2
    ovr0 = sr_overrun_count;
    fs_strobe = 1'b1;
    push_scan();
    @(posedge clk); #1;
    fs_strobe = 1'b0;
    @(posedge clk); #1;
    fs_strobe = 1'b1;
    @(posedge clk); #1;
    fs_strobe = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("overrun_plus1", sr_overrun_count, ovr0 + 16'd1);

    // Snap during slot 1
    cr_ramp_step = 16'h1;
    cr_target_gain = {24'h30, 24'h20, 24'h10};
    cr_target_output_gain = 24'h40;
    fs_strobe = 1'b1;
    @(posedge clk); #1;
    fs_strobe = 1'b0;
    @(posedge clk); #1;
    cmd_gain_snap = 1'b1;
    @(posedge clk); #1;
    cmd_gain_snap = 1'b0;
    snap_model();
    chk("snap_g0", ramp_gain[0], 24'h10);
    chk("snap_g1", ramp_gain[1], 24'h20);
    chk("snap_g2", ramp_gain[2], 24'h30);
    chk("snap_out", ramp_output_gain, 24'h40);
    chk("snap_busy", ramp_busy, 0);
    chk("snap_active", sr_ramp_active, 0);
    hit = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ramp_done) hit = 1'b1;
    end
    chk("snap_no_done", hit, 0);
    @(posedge clk); #1;

    // Snap coincident with strobe, idle and mid-scan
    cr_target_gain[1] = 24'h99;
    ovr0 = sr_overrun_count;
    cmd_gain_snap = 1'b1;
    fs_strobe = 1'b1;
    @(posedge clk); #1;
    cmd_gain_snap = 1'b0;
    fs_strobe = 1'b0;
    snap_model();
    chk("snapstb_busy", ramp_busy, 0);
    chk("snapstb_g1", ramp_gain[1], 24'h99);
    fs_strobe = 1'b1;
    @(posedge clk); #1;
    cmd_gain_snap = 1'b1;
    @(posedge clk); #1;
    cmd_gain_snap = 1'b0;
    fs_strobe = 1'b0;
    chk("snapstb_busy2", ramp_busy, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("snapstb_overrun", sr_overrun_count, ovr0);

    // Reset mid-scan (slot 1)
    cr_ramp_step = 16'h0;
    cr_target_gain = {24'h123, 24'h456, 24'h789};
    fs_strobe = 1'b1;
    @(posedge clk); #1;
    fs_strobe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_g0", ramp_gain[0], 0);
    chk("arst_out", ramp_output_gain, 0);
    chk("arst_busy", ramp_busy, 0);
    chk("arst_active", sr_ramp_active, 0);
    chk("arst_overrun", sr_overrun_count, 0);
    for (int k = 0; k < NS; k++) m_gain[k] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    hit = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ramp_busy) hit = 1'b1;
    end
    chk("post_rst_idle", hit, 0);
    @(posedge clk); #1;
    do_scan();

    // Overrun saturation: hold the strobe high until the counter tops out
    mon_en = 1'b0;
    fs_strobe = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 90000 && !hit; c++) begin
      @(posedge clk); #1;
      if (sr_overrun_count == 16'hFFFF) hit = 1'b1;
    end
    chk("overrun_reaches_max", hit, 1);
    fs_strobe = 1'b0;
    cmd_gain_snap = 1'b1;
    @(posedge clk); #1;
    cmd_gain_snap = 1'b0;
    fs_strobe = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fs_strobe = 1'b0;
    chk("overrun_saturates", sr_overrun_count, 16'hFFFF);
    repeat (8) @(posedge clk);
    #1;

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
